// File: rtl/gb_pkg.sv
// Shared Game Boy peripheral constants: register addresses, interrupt bit indices,
// handler vector base and the interrupt controller FSM state type.
package gb_pkg;

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  localparam int unsigned INT_VBLANK = 0;
  localparam int unsigned INT_LCD    = 1;
  localparam int unsigned INT_TIMER  = 2;
  localparam int unsigned INT_SERIAL = 3;
  localparam int unsigned INT_JOYPAD = 4;

  localparam logic [15:0] VEC_BASE = 16'h0040;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISPATCH
  } state_t;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-bit-first priority encoder over the five interrupt sources.
// Produces the winning index and a one-hot mask used to clear that IF bit.
module int_prio_enc
  import gb_pkg::*;
(
  input  logic [4:0] req,
  output logic       valid,
  output logic [2:0] index,
  output logic [4:0] mask
);

  always_comb begin
    valid = |req;
    index = 3'd0;
    mask  = 5'd0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = INT_JOYPAD; i >= 0; i--) begin
      if (req[i]) begin
        index   = 3'(i);
        mask    = 5'd0;
        mask[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_ctrl.sv
// Game Boy interrupt controller: IF/IE registers, IME with delayed EI, fixed-priority
// arbitration and the irq/ack dispatch handshake with the CPU.
module interrupt_ctrl #(
  parameter logic [15:0] ADDR_IF = gb_pkg::ADDR_IF,
  parameter logic [15:0] ADDR_IE = gb_pkg::ADDR_IE
) (
  input  logic        clockgb,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  indata,
  output logic [7:0]  outdata,
  input  logic        load,
  input  logic        store,
  input  logic        intv,
  input  logic        intl,
  input  logic        intt,
  input  logic        ints,
  input  logic        intj,
  input  logic        ei,
  input  logic        di,
  input  logic        reti,
  input  logic        instr_done,
  output logic        irq,
  input  logic        ack,
  output logic [15:0] vector,
  output logic        wake,
  output logic        ime
);
  import gb_pkg::*;

  logic [4:0]  if_q, if_d, if_wr, pulses, pending, pending_ack, clr_mask;
  logic [7:0]  ie_q, ie_d;
  logic        ime_q, ime_d, ei_pend_q, ei_pend_d;
  logic        irq_q, sel_if, sel_ie, dispatch, ack_valid;
  logic [2:0]  ack_idx;
  logic [15:0] vector_q, vector_d;
  state_t      state_q, state_d;

  assign sel_if   = (address == ADDR_IF);
  assign sel_ie   = (address == ADDR_IE);
  assign pulses   = {intj, ints, intt, intl, intv};
  assign pending  = if_q & ie_q[4:0];
  assign dispatch = (state_q == REQ) && ack;

  // Arbitration at ack sees a same-cycle IF store, so a software clear cancels the dispatch.
  assign if_wr       = (store && sel_if) ? indata[4:0] : if_q;
  assign pending_ack = if_wr & ie_q[4:0];

  int_prio_enc u_prio (
    .req   (pending_ack),
    .valid (ack_valid),
    .index (ack_idx),
    .mask  (clr_mask)
  );

  always_comb begin
    if_d = if_wr;
    if (dispatch) if_d = if_d & ~clr_mask;
    if_d = if_d | pulses;
    ie_d = (store && sel_ie) ? indata : ie_q;
  end

  always_comb begin
    ime_d     = ime_q;
    ei_pend_d = ei_pend_q;
    if (di) begin
      ime_d     = 1'b0;
      ei_pend_d = 1'b0;
    end else begin
      if (reti) ime_d = 1'b1;
      if (ei) begin
        ei_pend_d = 1'b1;
      end else if (ei_pend_q && instr_done) begin
        ime_d     = 1'b1;
        ei_pend_d = 1'b0;
      end
    end
    if (dispatch) ime_d = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    vector_d = vector_q;
    unique case (state_q)
      IDLE: begin
        if (ime_q && (pending != 5'd0)) state_d = REQ;
      end
      REQ: begin
        if (ack) begin
          state_d  = DISPATCH;
          vector_d = ack_valid ? (VEC_BASE + {10'd0, ack_idx, 3'd0}) : 16'h0000;
        end else if (!ime_q || (pending == 5'd0)) begin
          state_d = IDLE;
        end
      end
      DISPATCH: begin
        if (!ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clockgb or posedge reset) begin
    if (reset) begin
      if_q      <= 5'd0;
      ie_q      <= 8'd0;
      ime_q     <= 1'b0;
      ei_pend_q <= 1'b0;
      state_q   <= IDLE;
      irq_q     <= 1'b0;
      vector_q  <= 16'h0000;
    end else begin
      if_q      <= if_d;
      ie_q      <= ie_d;
      ime_q     <= ime_d;
      ei_pend_q <= ei_pend_d;
      state_q   <= state_d;
      irq_q     <= (state_d == REQ);
      vector_q  <= vector_d;
    end
  end

  always_comb begin
    outdata = 8'h00;
    if (load) begin
      if (sel_if)      outdata = {3'b111, if_q};
      else if (sel_ie) outdata = ie_q;
    end
  end

  assign irq    = irq_q;
  assign vector = vector_q;
  assign wake   = |pending;
  assign ime    = ime_q;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl: a behavioural model checked every cycle plus
// hand-computed expectations at key points of each scenario.
module tb_interrupt_ctrl;

  logic        clockgb = 1'b0;
  logic        reset   = 1'b1;
  logic [15:0] address = 16'h0000;
  logic [7:0]  indata  = 8'h00;
  logic [7:0]  outdata;
  logic        load = 1'b0, store = 1'b0;
  logic        intv = 1'b0, intl = 1'b0, intt = 1'b0, ints = 1'b0, intj = 1'b0;
  logic        ei = 1'b0, di = 1'b0, reti = 1'b0, instr_done = 1'b0;
  logic        irq, ack = 1'b0, wake, ime;
  logic [15:0] vector;

  int total = 0;
  int bad   = 0;

  interrupt_ctrl dut (
    .clockgb    (clockgb),
    .reset      (reset),
    .address    (address),
    .indata     (indata),
    .outdata    (outdata),
    .load       (load),
    .store      (store),
    .intv       (intv),
    .intl       (intl),
    .intt       (intt),
    .ints       (ints),
    .intj       (intj),
    .ei         (ei),
    .di         (di),
    .reti       (reti),
    .instr_done (instr_done),
    .irq        (irq),
    .ack        (ack),
    .vector     (vector),
    .wake       (wake),
    .ime        (ime)
  );

  always #5 clockgb = ~clockgb;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = waiting, 1 = requesting, 2 = dispatching.
  logic [4:0]  m_if, n_if, m_pend, m_wif, m_peff, m_pulse;
  logic [7:0]  m_ie;
  logic        m_ime, m_ep, n_ime, n_ep;
  int          m_phase, n_phase, m_win;
  logic [15:0] m_vec;

  function automatic int lowest(input logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] model_rd();
    if (!load) return 8'h00;
    if (address == 16'hFF0F) return {3'b111, m_if};
    if (address == 16'hFFFF) return m_ie;
    return 8'h00;
  endfunction

  always @(posedge clockgb or posedge reset) begin
    if (reset) begin
      m_if = 5'd0; m_ie = 8'd0; m_ime = 1'b0; m_ep = 1'b0; m_phase = 0; m_vec = 16'h0;
    end else begin
      m_pend  = m_if & m_ie[4:0];
      m_wif   = (store && address == 16'hFF0F) ? indata[4:0] : m_if;
      m_pulse = {intj, ints, intt, intl, intv};
      n_if    = m_wif;
      n_ime   = m_ime;
      n_ep    = m_ep;
      n_phase = m_phase;
      if (di) begin
        n_ime = 1'b0; n_ep = 1'b0;
      end else begin
        if (reti) n_ime = 1'b1;
        if (ei) n_ep = 1'b1;
        else if (m_ep && instr_done) begin n_ime = 1'b1; n_ep = 1'b0; end
      end
      if (m_phase == 0 && m_ime && m_pend != 0) n_phase = 1;
      else if (m_phase == 1 && ack) begin
        m_peff = m_wif & m_ie[4:0];
        m_win  = lowest(m_peff);
        if (m_win >= 0) begin
          m_vec = 16'h0040 + 16'(8 * m_win);
          n_if[m_win] = 1'b0;
        end else begin
          m_vec = 16'h0000;
        end
        n_ime   = 1'b0;
        n_phase = 2;
      end else if (m_phase == 1 && (!m_ime || m_pend == 0)) n_phase = 0;
      else if (m_phase == 2 && !ack) n_phase = 0;
      if (store && address == 16'hFFFF) m_ie = indata;
      m_if    = n_if | m_pulse;
      m_ime   = n_ime;
      m_ep    = n_ep;
      m_phase = n_phase;
    end
  end

  always @(negedge clockgb) begin
    if (reset === 1'b0) begin
      check("model_irq", 16'(irq), 16'(m_phase == 1));
      check("model_ime", 16'(ime), 16'(m_ime));
      check("model_wake", 16'(wake), 16'(|(m_if & m_ie[4:0])));
      check("model_outdata", 16'(outdata), 16'(model_rd()));
      if (m_phase == 2) check("model_vector", vector, m_vec);
    end
  end

  task automatic tick();
    @(posedge clockgb);
    #1;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    address = a; indata = d; store = 1'b1;
    tick();
    store = 1'b0; address = 16'h0000; indata = 8'h00;
  endtask

  task automatic rd_check(input string name, input logic [15:0] a, input logic [7:0] exp);
    address = a; load = 1'b1;
    #1;
    check(name, 16'(outdata), 16'(exp));
    load = 1'b0; address = 16'h0000;
  endtask

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    check("rst_irq", 16'(irq), 16'h0);
    check("rst_ime", 16'(ime), 16'h0);
    check("rst_wake", 16'(wake), 16'h0);
    rd_check("rst_if", 16'hFF0F, 8'hE0);
    rd_check("rst_ie", 16'hFFFF, 8'h00);

    // Basic dispatch of the timer interrupt.
    bus_wr(16'hFFFF, 8'h04);
    reti = 1'b1; tick(); reti = 1'b0;
    check("basic_ime_on", 16'(ime), 16'h1);
    intt = 1'b1; tick(); intt = 1'b0;
    check("basic_irq_early", 16'(irq), 16'h0);
    check("basic_wake", 16'(wake), 16'h1);
    tick();
    check("basic_irq", 16'(irq), 16'h1);
    ack = 1'b1; tick();
    check("basic_vec", vector, 16'h0050);
    check("basic_irq_off", 16'(irq), 16'h0);
    check("basic_ime_off", 16'(ime), 16'h0);
    rd_check("basic_if", 16'hFF0F, 8'hE0);
    ack = 1'b0; tick();

    // Priority: vblank beats serial, serial served after reti.
    bus_wr(16'hFFFF, 8'h1F);
    reti = 1'b1; tick(); reti = 1'b0;
    intv = 1'b1; ints = 1'b1; tick(); intv = 1'b0; ints = 1'b0;
    tick();
    ack = 1'b1; tick();
    check("prio_vec1", vector, 16'h0040);
    rd_check("prio_if1", 16'hFF0F, 8'hE8);
    ack = 1'b0; tick();
    reti = 1'b1; tick(); reti = 1'b0;
    tick();
    check("prio_irq2", 16'(irq), 16'h1);
    ack = 1'b1; tick();
    check("prio_vec2", vector, 16'h0058);
    rd_check("prio_if2", 16'hFF0F, 8'hE0);
    ack = 1'b0; tick();

    // Cancellation: IF cleared by software in the ack cycle.
    reti = 1'b1; tick(); reti = 1'b0;
    intl = 1'b1; tick(); intl = 1'b0;
    tick();
    check("cancel_irq", 16'(irq), 16'h1);
    address = 16'hFF0F; indata = 8'h00; store = 1'b1; ack = 1'b1;
    tick();
    store = 1'b0; address = 16'h0000;
    check("cancel_vec", vector, 16'h0000);
    check("cancel_ime", 16'(ime), 16'h0);
    rd_check("cancel_if", 16'hFF0F, 8'hE0);
    ack = 1'b0; tick();

    // EI delay and DI precedence.
    ei = 1'b1; tick(); ei = 1'b0;
    check("ei_wait1", 16'(ime), 16'h0);
    tick();
    check("ei_wait2", 16'(ime), 16'h0);
    instr_done = 1'b1; tick(); instr_done = 1'b0;
    check("ei_on", 16'(ime), 16'h1);
    di = 1'b1; tick(); di = 1'b0;
    check("di_off", 16'(ime), 16'h0);
    ei = 1'b1; instr_done = 1'b1; tick(); ei = 1'b0; instr_done = 1'b0;
    check("ei_same_done", 16'(ime), 16'h0);
    instr_done = 1'b1; tick(); instr_done = 1'b0;
    check("ei_late_done", 16'(ime), 16'h1);
    di = 1'b1; tick();
    ei = 1'b1; tick(); di = 1'b0; ei = 1'b0;
    instr_done = 1'b1; tick(); instr_done = 1'b0;
    check("di_beats_ei", 16'(ime), 16'h0);

    // Pulse beats a same-cycle store of zero; wake without IME.
    address = 16'hFF0F; indata = 8'h00; store = 1'b1; intj = 1'b1;
    tick();
    store = 1'b0; intj = 1'b0; address = 16'h0000;
    rd_check("conflict_if", 16'hFF0F, 8'hF0);
    check("conflict_wake", 16'(wake), 16'h1);
    tick();
    check("conflict_irq", 16'(irq), 16'h0);

    // Reset while dispatching the joypad interrupt.
    reti = 1'b1; tick(); reti = 1'b0;
    tick();
    ack = 1'b1; tick();
    check("rst_disp_vec", vector, 16'h0060);
    reset = 1'b1;
    #1;
    check("rstd_irq", 16'(irq), 16'h0);
    check("rstd_ime", 16'(ime), 16'h0);
    check("rstd_wake", 16'(wake), 16'h0);
    check("rstd_vec", vector, 16'h0000);
    check("rstd_out", 16'(outdata), 16'h0);
    ack = 1'b0; tick();
    reset = 1'b0; tick();
    rd_check("rstd_if", 16'hFF0F, 8'hE0);
    rd_check("rstd_ie", 16'hFFFF, 8'h00);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
